// File: rtl/hazard_ctrl.sv
// Hazard/stall controller: operand forwarding, load-use stall, branch flush and data-memory wait FSM.
// Optional saturating performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic [1:0]       ResultSrcE,
    input  logic             PCSrcE,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             StallW,
    output logic             FlushD,
    output logic             FlushE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             MemErr,
    output logic [CNT_W-1:0] LoadUseCnt,
    output logic [CNT_W-1:0] FlushCnt,
    output logic [CNT_W-1:0] MemWaitCnt
);

    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [7:0] WCNT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state, state_nxt;
    logic [7:0] wcnt, wcnt_nxt;
    logic       memerr_nxt;
    logic       lw_stall;
    logic       mem_stall;
    logic       timeout;

    always_comb begin
        ForwardAE = 2'b00;
        if (RegWriteM && (RdM == Rs1E) && (Rs1E != 5'd0))
            ForwardAE = 2'b10;
        else if (RegWriteW && (RdW == Rs1E) && (Rs1E != 5'd0))
            ForwardAE = 2'b01;

        ForwardBE = 2'b00;
        if (RegWriteM && (RdM == Rs2E) && (Rs2E != 5'd0))
            ForwardBE = 2'b10;
        else if (RegWriteW && (RdW == Rs2E) && (Rs2E != 5'd0))
            ForwardBE = 2'b01;
    end

    assign lw_stall = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                      ((RdE == Rs1D) || (RdE == Rs2D));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            wcnt   <= '0;
            MemErr <= 1'b0;
        end else begin
            state  <= state_nxt;
            wcnt   <= wcnt_nxt;
            MemErr <= memerr_nxt;
        end
    end

    // A completing access on the timeout cycle wins over the error.
    always_comb begin
        state_nxt  = state;
        wcnt_nxt   = wcnt;
        memerr_nxt = MemErr;
        timeout    = 1'b0;
        mem_stall  = 1'b0;
        case (state)
            IDLE: begin
                if (MemReqM && !MemReadyM) begin
                    state_nxt = WAIT;
                    wcnt_nxt  = '0;
                    mem_stall = 1'b1;
                end
            end
            WAIT: begin
                timeout = !MemReadyM && (wcnt == WCNT_LAST);
                if (MemReadyM) begin
                    state_nxt = IDLE;
                end else if (timeout) begin
                    state_nxt  = IDLE;
                    memerr_nxt = 1'b1;
                end else begin
                    wcnt_nxt  = wcnt + 8'd1;
                    mem_stall = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign StallF = lw_stall || mem_stall;
    assign StallD = lw_stall || mem_stall;
    assign StallE = mem_stall;
    assign StallM = mem_stall;
    assign StallW = mem_stall;
    assign FlushD = PCSrcE && !mem_stall;
    assign FlushE = (lw_stall || PCSrcE) && !mem_stall;

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            LoadUseCnt <= '0;
            FlushCnt   <= '0;
            MemWaitCnt <= '0;
        end else begin
            if (lw_stall && !mem_stall && (LoadUseCnt != '1))
                LoadUseCnt <= LoadUseCnt + 1'b1;
            if (FlushD && (FlushCnt != '1))
                FlushCnt <= FlushCnt + 1'b1;
            if (mem_stall && (MemWaitCnt != '1))
                MemWaitCnt <= MemWaitCnt + 1'b1;
        end
    end
`else
    assign LoadUseCnt = '0;
    assign FlushCnt   = '0;
    assign MemWaitCnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (MEM_TIMEOUT=4, CNT_W=2).
module tb_hazard_ctrl;

    localparam int unsigned CW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic          RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;
    logic [1:0]    ResultSrcE;
    logic          StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, MemErr;
    logic [1:0]    ForwardAE, ForwardBE;
    logic [CW-1:0] LoadUseCnt, FlushCnt, MemWaitCnt;

    int n_checks = 0;
    int n_fail   = 0;

    hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM), .StallW(StallW),
        .FlushD(FlushD), .FlushE(FlushE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .MemErr(MemErr), .LoadUseCnt(LoadUseCnt), .FlushCnt(FlushCnt), .MemWaitCnt(MemWaitCnt)
    );

    always #5 clk = ~clk;

    // {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, StallW, FlushD, FlushE}
    function automatic logic [10:0] ctl();
        return {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, StallW, FlushD, FlushE};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
        RegWriteM = 0; RegWriteW = 0; ResultSrcE = 2'b00;
        PCSrcE = 0; MemReqM = 0; MemReadyM = 0;
    endtask

    // Advance one clock and leave inputs free to change 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1;
        #3;
        rst = 0;
        tick();
    endtask

    function automatic logic [15:0] cnt_exp(input int v);
`ifdef HAZARD_PERF_CNT_EN
        return 16'(v);
`else
        return 16'(0 * v);
`endif
    endfunction

    typedef struct {
        logic [4:0]  rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic        rwm, rww;
        logic [1:0]  rsrc;
        logic        pcs;
        logic [10:0] exp;
    } vec_t;

    vec_t vecs[11];

    initial begin
        //              rs1d rs2d rs1e rs2e rde rdm rdw rwm rww rsrc  pcs  exp
        vecs[0]  = '{0, 0, 5, 0, 0, 5, 5, 1, 1, 2'b00, 0, 11'b10_00_00000_00};
        vecs[1]  = '{0, 0, 5, 0, 0, 6, 5, 1, 1, 2'b00, 0, 11'b01_00_00000_00};
        vecs[2]  = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 2'b00, 0, 11'b00_00_00000_00};
        vecs[3]  = '{0, 0, 0, 9, 0, 9, 9, 0, 1, 2'b00, 0, 11'b00_01_00000_00};
        vecs[4]  = '{0, 0, 9, 9, 0, 9, 9, 1, 1, 2'b00, 0, 11'b10_10_00000_00};
        vecs[5]  = '{0, 7, 0, 0, 7, 0, 0, 0, 0, 2'b01, 0, 11'b00_00_11000_01};
        vecs[6]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 11'b00_00_00000_00};
        vecs[7]  = '{7, 0, 0, 0, 7, 0, 0, 0, 0, 2'b10, 0, 11'b00_00_00000_00};
        vecs[8]  = '{7, 0, 0, 0, 7, 0, 0, 0, 0, 2'b01, 0, 11'b00_00_11000_01};
        vecs[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 11'b00_00_00000_11};
        vecs[10] = '{0, 7, 0, 0, 7, 0, 0, 0, 0, 2'b01, 1, 11'b00_00_11000_11};

        clear_inputs();
        rst = 1;
        #2;
        check("reset_memerr", 16'(MemErr), 16'd0);
        check("reset_cnts", {10'd0, LoadUseCnt, FlushCnt, MemWaitCnt}, 16'd0);
        check("reset_ctl", 16'(ctl()), 16'd0);
        rst = 0;
        tick();

        for (int i = 0; i < 11; i++) begin
            Rs1D = vecs[i].rs1d; Rs2D = vecs[i].rs2d; Rs1E = vecs[i].rs1e;
            Rs2E = vecs[i].rs2e; RdE = vecs[i].rde;   RdM = vecs[i].rdm;
            RdW = vecs[i].rdw;   RegWriteM = vecs[i].rwm; RegWriteW = vecs[i].rww;
            ResultSrcE = vecs[i].rsrc; PCSrcE = vecs[i].pcs;
            #2;
            check($sformatf("vec%0d", i), 16'(ctl()), 16'(vecs[i].exp));
            tick();
        end

        // Three-cycle memory wait with a pending branch flush held off.
        clear_inputs();
        do_reset();
        MemReqM = 1; MemReadyM = 0; PCSrcE = 1;
        for (int c = 0; c < 3; c++) begin
            #2;
            check($sformatf("memwait_c%0d", c), 16'(ctl()), 16'b000_0011_1110_0);
            tick();
        end
        MemReadyM = 1;
        #2;
        check("memwait_done", 16'(ctl()), 16'b000_0000_0001_1);
        tick();
        clear_inputs();
        #2;
        check("memwait_cnt", 16'(MemWaitCnt), cnt_exp(3));
        check("memwait_flushcnt", 16'(FlushCnt), cnt_exp(1));
        check("memwait_noerr", 16'(MemErr), 16'd0);

        // Timeout: four stall cycles, the fifth releases and raises MemErr.
        do_reset();
        MemReqM = 1; MemReadyM = 0;
        for (int c = 0; c < 4; c++) begin
            #2;
            check($sformatf("timeout_stall%0d", c), 16'(StallE), 16'd1);
            check($sformatf("timeout_err%0d", c), 16'(MemErr), 16'd0);
            tick();
        end
        #2;
        check("timeout_release", 16'(ctl()), 16'd0);
        tick();
        MemReqM = 0;
        #2;
        check("timeout_memerr", 16'(MemErr), 16'd1);
        check("timeout_idle", 16'(StallF), 16'd0);
        tick();
        tick();
        check("memerr_sticky", 16'(MemErr), 16'd1);
        rst = 1;
        #1;
        check("memerr_async_clr", 16'(MemErr), 16'd0);
        rst = 0;
        tick();

        // Load-use counting, suppressed while memory is frozen, then flush saturation.
        clear_inputs();
        do_reset();
        ResultSrcE = 2'b01; RdE = 7; Rs1D = 7;
        tick();
        tick();
        MemReqM = 1; MemReadyM = 0;
        #2;
        check("lw_mem_freeze", 16'(ctl()), 16'b000_0011_1110_0);
        tick();
        clear_inputs();
        MemReadyM = 1;
        #2;
        check("wait_exit", 16'(ctl()), 16'd0);
        tick();
        MemReadyM = 0;
        check("loaduse_cnt", 16'(LoadUseCnt), cnt_exp(2));
        check("memwait_cnt2", 16'(MemWaitCnt), cnt_exp(1));
        PCSrcE = 1;
        for (int c = 0; c < 5; c++) tick();
        PCSrcE = 0;
        check("flush_sat", 16'(FlushCnt), cnt_exp(3));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
